// File: rtl/div_mon_pkg.sv
// Shared types and constants for the divided-clock monitor.
package div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_e;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Brings the asynchronous divided clock into the clk domain and flags its edges.
module sync_edge_det
    import div_mon_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic level
);

    logic [SYNC_DEPTH-1:0] sync_p0;
    logic                  last_p1;

    // synchronizer chain, then one extra stage holding the previous level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            last_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_DEPTH-2:0], din};
            last_p1 <= sync_p0[SYNC_DEPTH-1];
        end
    end

    assign level = sync_p0[SYNC_DEPTH-1];
    assign rise  = level & ~last_p1;
    assign fall  = ~level & last_p1;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period and high time of a divided clock and tracks frequency lock.
// Optional duty-cycle qualification is enabled by defining DIV_MON_DUTY_CHECK_EN.
module div_clk_monitor
    import div_mon_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_in,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [3:0]       tol,
    input  logic             err_clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic             locked,
    output logic             err
);

    localparam int               RUN_W    = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic within_tol(input logic signed [CNT_W+1:0] diff,
                                        input logic [3:0]              t);
        logic signed [CNT_W+1:0] mag;
        mag = diff[CNT_W+1] ? -diff : diff;
        return mag <= $signed((CNT_W+2)'(t));
    endfunction

    logic rise;
    logic fall;
    logic level;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (div_in),
        .rise  (rise),
        .fall  (fall),
        .level (level)
    );

    mon_state_e       state;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic             hi_run;
    logic [RUN_W-1:0] good_run;

    logic signed [CNT_W:0] per_diff;
    logic                  good;
    logic                  timeout;

    assign per_diff = $signed({1'b0, per_cnt}) - $signed({1'b0, exp_period});

`ifdef DIV_MON_DUTY_CHECK_EN
    logic signed [CNT_W+1:0] duty_diff;
    assign duty_diff = $signed({1'b0, hi_cnt, 1'b0}) - $signed({2'b00, per_cnt});
`endif

    always_comb begin
        good = within_tol((CNT_W+2)'(per_diff), tol);
`ifdef DIV_MON_DUTY_CHECK_EN
        good = good && within_tol(duty_diff, tol);
`endif
    end

    // A saturated counter means div_in stopped toggling.
    assign timeout = (per_cnt == CNT_MAX) || (hi_run && level && hi_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            hi_run     <= 1'b0;
            good_run   <= '0;
            period     <= '0;
            high_time  <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
        end else begin
            period_vld <= 1'b0;
            if (err_clr) begin
                err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= MEASURE;
                        per_cnt  <= CNT_ONE;
                        hi_cnt   <= CNT_ONE;
                        hi_run   <= 1'b1;
                        good_run <= '0;
                    end
                end
                default: begin
                    if (rise) begin
                        per_cnt    <= CNT_ONE;
                        hi_cnt     <= CNT_ONE;
                        hi_run     <= 1'b1;
                        period     <= per_cnt;
                        high_time  <= hi_cnt;
                        period_vld <= 1'b1;
                        if (good) begin
                            if (state == MEASURE) begin
                                if (good_run == RUN_LAST) begin
                                    state    <= LOCKED;
                                    locked   <= 1'b1;
                                    good_run <= '0;
                                end else begin
                                    good_run <= good_run + 1'b1;
                                end
                            end
                        end else begin
                            good_run <= '0;
                            if (state == LOCKED) begin
                                state  <= MEASURE;
                                locked <= 1'b0;
                                err    <= 1'b1;
                            end
                        end
                    end else if (timeout) begin
                        state    <= IDLE;
                        locked   <= 1'b0;
                        err      <= 1'b1;
                        per_cnt  <= '0;
                        hi_cnt   <= '0;
                        hi_run   <= 1'b0;
                        good_run <= '0;
                    end else begin
                        per_cnt <= sat_inc(per_cnt);
                        if (fall) begin
                            hi_run <= 1'b0;
                        end else if (hi_run) begin
                            hi_cnt <= sat_inc(hi_cnt);
                        end
                    end
                end
            endcase
        end
    end

endmodule
